uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 125 ++++++++++++
 tb/tb_uart_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: valid/ready byte in, start/data/parity/stop frame out on tx_o
module uart_tx #(
  parameter int CLK_DIV    = 868,
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              baud_wrap;

  assign baud_wrap = (baud_q == BAUD_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    if (state_q != S_IDLE) begin
      baud_d = baud_wrap ? '0 : baud_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          state_d  = S_START;
          shift_d  = data_i;
          parity_d = (^data_i) ^ PARITY_ODD[0];
          baud_d   = '0;
          bit_d    = '0;
        end
      end
      S_START: begin
        if (baud_wrap) state_d = S_DATA;
      end
      S_DATA: begin
        if (baud_wrap) begin
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (baud_wrap) state_d = S_STOP;
      end
      S_STOP: begin
        if (baud_wrap) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // The line level is chosen from the state being entered so tx_o lands one cycle after accept.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_comb begin
    ready_o = (state_q == S_IDLE);
    busy_o  = (state_q != S_IDLE);
    done_o  = (state_q == S_STOP) && baud_wrap && (bit_q == STOP_LAST);
    tx_o    = tx_q;
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx: 8N1, even parity/2 stop, odd parity/1 stop instances
module tb_uart_tx;

  localparam int DIV = 4;
  localparam int NI  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_s [NI];
  logic [NI-1:0] valid_s;
  logic [NI-1:0] ready_s, tx_s, busy_s, done_s;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  bit rst_prev = 1'b1;

  logic [7:0] exp_q [NI][$];
  logic [1:0] wave  [NI][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx #(
      .CLK_DIV   (DIV),
      .DATA_W    (8),
      .PARITY_EN ((g == 0) ? 0 : 1),
      .PARITY_ODD((g == 2) ? 1 : 0),
      .STOP_BITS ((g == 1) ? 2 : 1)
    ) u_dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .data_i (data_s[g]),
      .valid_i(valid_s[g]),
      .ready_o(ready_s[g]),
      .tx_o   (tx_s[g]),
      .busy_o (busy_s[g]),
      .done_o (done_s[g])
    );
  end

  function automatic bit cfg_parity(int i);
    return i != 0;
  endfunction

  function automatic bit cfg_odd(int i);
    return i == 2;
  endfunction

  function automatic int cfg_stops(int i);
    return (i == 1) ? 2 : 1;
  endfunction

  task automatic chk(input bit ok, input string nm, input int i, input logic [3:0] act, input logic [3:0] want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s inst=%0d t=%0t got{rdy,busy,done,tx}=%b want=%b", nm, i, $time, act, want);
    end
  endtask

  // Expected line, one entry per clock: {done, tx}, built from the frame rules.
  task automatic build_wave(input int i, input logic [7:0] b);
    bit bits[$];
    int ones;
    logic [1:0] e;
    ones = 0;
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) begin
      bits.push_back(b[k]);
      ones += int'(b[k]);
    end
    if (cfg_parity(i)) bits.push_back(bit'(ones % 2) ^ cfg_odd(i));
    for (int k = 0; k < cfg_stops(i); k++) bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int c = 0; c < DIV; c++) wave[i].push_back({1'b0, bits[k]});
    end
    e = wave[i].pop_back();
    wave[i].push_back({1'b1, e[0]});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < NI; i++) begin
        logic [3:0] act;
        logic [1:0] e;
        act = {ready_s[i], busy_s[i], done_s[i], tx_s[i]};
        if (rst_prev) wave[i].delete();
        if (wave[i].size() > 0) begin
          e = wave[i].pop_front();
          chk(act === {2'b01, e}, "frame", i, act, {2'b01, e});
        end else begin
          chk(act === 4'b1001, "idle", i, act, 4'b1001);
        end
        if (!rst && valid_s[i] && ready_s[i]) begin
          if (exp_q[i].size() == 0) begin
            chk(1'b0, "unexpected_accept", i, act, 4'b0000);
          end else begin
            build_wave(i, exp_q[i].pop_front());
          end
        end
      end
    end
    rst_prev = rst;
  end

  // Inputs change only #1 after a rising edge so the monitor sees what the DUT samples.
  task automatic send(input int i, input logic [7:0] b, input bit keep);
    int n;
    data_s[i]  = b;
    exp_q[i].push_back(b);
    valid_s[i] = 1'b1;
    n = 0;
    while (!ready_s[i] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      chk(1'b0, "accept_timeout", i, {ready_s[i], busy_s[i], done_s[i], tx_s[i]}, 4'b1001);
      valid_s[i] = 1'b0;
      void'(exp_q[i].pop_back());
    end else begin
      @(posedge clk);
      #1;
      if (!keep) valid_s[i] = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    valid_s = '0;
    for (int i = 0; i < NI; i++) data_s[i] = 8'h00;
    @(posedge clk);
    #1 mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_cycles(20);

    send(0, 8'hA5, 1'b0);
    idle_cycles(50);
    send(1, 8'h07, 1'b0);
    send(2, 8'h07, 1'b0);
    idle_cycles(60);
    send(1, 8'h00, 1'b0);
    idle_cycles(60);

    send(0, 8'h55, 1'b1);
    send(0, 8'h0F, 1'b0);
    idle_cycles(50);

    send(0, 8'hC3, 1'b0);
    idle_cycles(8);
    data_s[0]  = 8'hFF;
    valid_s[0] = 1'b1;
    idle_cycles(1);
    valid_s[0] = 1'b0;
    data_s[0]  = 8'h00;
    idle_cycles(50);

    send(0, 8'h3C, 1'b0);
    idle_cycles(15);
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    idle_cycles(3);
    send(0, 8'h81, 1'b0);
    idle_cycles(50);

    repeat (30) begin
      int i;
      i = $urandom_range(0, NI - 1);
      if ($urandom_range(0, 3) == 0) begin
        send(i, 8'($urandom), 1'b1);
        send(i, 8'($urandom), 1'b0);
      end else begin
        send(i, 8'($urandom), 1'b0);
      end
      data_s[i] = 8'($urandom);
      idle_cycles($urandom_range(0, 12));
    end

    idle_cycles(120);
    for (int i = 0; i < NI; i++) begin
      chk(exp_q[i].size() == 0 && wave[i].size() == 0, "drain", i,
          4'(exp_q[i].size()), 4'b0000);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
